// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Self-checking monitor for a single-cycle RISC-V core's data-memory write
//   port. A table of up to NUM_CHECKS expected (address, data) stores is
//   loaded while idle; once armed, every store the core makes is compared
//   against the table, either in table order (ORDERED=1) or in any order
//   (ORDERED=0). The checker ends in PASS when every active entry has been
//   matched, or in FAIL with a cause code and the offending store.
//
// Ports
//   clk, reset        : single rising-edge clock, synchronous active-high reset
//   cfg_we/idx/addr/data : table write port, honoured only in IDLE
//   cfg_num           : number of active entries, latched on start
//   start             : arm the checker (honoured in IDLE, PASS and FAIL)
//   MemWrite/DataAddr/WriteData : snooped core store port
//   busy/pass/fail    : registered state flags (ARMED / PASS / FAIL)
//   fail_code         : 0 none, 1 unexpected address, 2 data mismatch,
//                       3 duplicate store, 4 timeout
//   fail_addr/data    : the failing store (0 on timeout)
//   match_count       : entries matched in the current run
//   cycle_count       : cycles spent in ARMED, saturating at TIMEOUT
//   dbg_state         : FSM state (0 IDLE, 1 ARMED, 2 PASS, 3 FAIL)
//
// Handshake: there is no backpressure. A store is a single-cycle event,
// valid whenever MemWrite is high at a rising edge; the checker always
// accepts it and reflects the result in its outputs after that same edge.
module mem_write_checker #(
    parameter int NUM_CHECKS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 1024,
    parameter int ORDERED    = 1,
    parameter int STRICT     = 1,
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CW = $clog2(NUM_CHECKS + 1),
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CW-1:0]     cfg_num,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAddr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [2:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CW-1:0]     match_count,
    output logic [TW-1:0]     cycle_count,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PASS  = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_ADDR    = 3'd1;
    localparam logic [2:0] FC_DATA    = 3'd2;
    localparam logic [2:0] FC_DUP     = 3'd3;
    localparam logic [2:0] FC_TIMEOUT = 3'd4;

    localparam logic [TW-1:0] CYC_MAX = TW'(TIMEOUT);

    logic [ADDR_W-1:0]     tbl_addr [NUM_CHECKS];
    logic [DATA_W-1:0]     tbl_data [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] hit_q, hit_d;
    logic [CW-1:0]         num_q, num_d;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     mc_d;
    logic [TW-1:0]     cc_d;
    logic [2:0]        code_d;
    logic [ADDR_W-1:0] faddr_d;
    logic [DATA_W-1:0] fdata_d;

    // Table lookup results for the current store
    logic              o_cur_addr_eq, o_cur_data_eq, o_earlier, o_later;
    logic              u_any, u_found, u_data_eq;
    logic [NUM_CHECKS-1:0] u_mask;

    // Store classification
    logic       ev_match, ev_fail;
    logic [2:0] ev_code;

    always_comb begin
        o_cur_addr_eq = 1'b0;
        o_cur_data_eq = 1'b0;
        o_earlier     = 1'b0;
        o_later       = 1'b0;
        u_any         = 1'b0;
        u_found       = 1'b0;
        u_data_eq     = 1'b0;
        u_mask        = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            // Ordered view: the entry under test is entry[match_count];
            // entries below it are already matched, entries above are pending.
            if (CW'(i) == match_count) begin
                o_cur_addr_eq = (tbl_addr[i] == DataAddr);
                o_cur_data_eq = (tbl_data[i] == WriteData);
            end
            if ((CW'(i) < match_count) && (tbl_addr[i] == DataAddr))
                o_earlier = 1'b1;
            if ((CW'(i) > match_count) && (CW'(i) < num_q) && (tbl_addr[i] == DataAddr))
                o_later = 1'b1;
            // Unordered view: the lowest-index active, still-unhit entry with
            // this address claims the store. If every such entry is already
            // hit, the store is a duplicate.
            if ((CW'(i) < num_q) && (tbl_addr[i] == DataAddr)) begin
                u_any = 1'b1;
                if (!hit_q[i] && !u_found) begin
                    u_found   = 1'b1;
                    u_data_eq = (tbl_data[i] == WriteData);
                    u_mask[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ev_match = 1'b0;
        ev_fail  = 1'b0;
        ev_code  = FC_NONE;
        if (MemWrite) begin
            if (ORDERED != 0) begin
                if (o_cur_addr_eq) begin
                    if (o_cur_data_eq) ev_match = 1'b1;
                    else begin ev_fail = 1'b1; ev_code = FC_DATA; end
                end else if (o_earlier) begin
                    ev_fail = 1'b1; ev_code = FC_DUP;
                end else if (o_later || (STRICT != 0)) begin
                    ev_fail = 1'b1; ev_code = FC_ADDR;
                end
            end else begin
                if (u_found) begin
                    if (u_data_eq) ev_match = 1'b1;
                    else begin ev_fail = 1'b1; ev_code = FC_DATA; end
                end else if (u_any) begin
                    ev_fail = 1'b1; ev_code = FC_DUP;
                end else if (STRICT != 0) begin
                    ev_fail = 1'b1; ev_code = FC_ADDR;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mc_d    = match_count;
        cc_d    = cycle_count;
        hit_d   = hit_q;
        num_d   = num_q;
        code_d  = fail_code;
        faddr_d = fail_addr;
        fdata_d = fail_data;
        case (state_q)
            S_ARMED: begin
                cc_d = (cycle_count == CYC_MAX) ? cycle_count : cycle_count + TW'(1);
                if (ev_match) begin
                    mc_d = match_count + CW'(1);
                    if (ORDERED == 0) hit_d = hit_q | u_mask;
                end
                // Completing match beats a store failure, which beats timeout.
                if (ev_match && (mc_d == num_q)) begin
                    state_d = S_PASS;
                end else if (ev_fail) begin
                    state_d = S_FAIL;
                    code_d  = ev_code;
                    faddr_d = DataAddr;
                    fdata_d = WriteData;
                end else if (cc_d == CYC_MAX) begin
                    state_d = S_FAIL;
                    code_d  = FC_TIMEOUT;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end
            default: begin
                // IDLE, PASS and FAIL all accept start; ARMED ignores it.
                if (start) begin
                    num_d   = cfg_num;
                    mc_d    = '0;
                    cc_d    = '0;
                    hit_d   = '0;
                    code_d  = FC_NONE;
                    faddr_d = '0;
                    fdata_d = '0;
                    state_d = (cfg_num == '0) ? S_PASS : S_ARMED;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= FC_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
            match_count <= '0;
            cycle_count <= '0;
            hit_q       <= '0;
            num_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= (state_d == S_ARMED);
            pass        <= (state_d == S_PASS);
            fail        <= (state_d == S_FAIL);
            fail_code   <= code_d;
            fail_addr   <= faddr_d;
            fail_data   <= fdata_d;
            match_count <= mc_d;
            cycle_count <= cc_d;
            hit_q       <= hit_d;
            num_q       <= num_d;
        end
    end

    // Table is written only in IDLE. A write coinciding with start lands at
    // the same edge that arms, so the run already sees the new entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (cfg_we && (state_q == S_IDLE)) begin
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable self-checking monitor for the single-cycle RISC-V core's data-memory write port. It snoops `MemWrite`/`DataAddr`/`WriteData` each cycle and compares them against a programmable table of up to `NUM_CHECKS` expected stores, in order or in any order. It reports pass, fail-with-cause, and progress counters. It sits beside the core in simulation and FPGA bring-up, and replaces hard-coded single-store bench checks with a parametrised, multi-store, timeout-guarded checker.

## Interface
- `NUM_CHECKS`, 4: expected-store table depth (1..16).
- `ADDR_W`, 32: data address width.
- `DATA_W`, 32: store data width.
- `TIMEOUT`, 1024: maximum cycles in ARMED before failure (≥1).
- `ORDERED`, 1: 1 = stores must match table order; 0 = any order.
- `STRICT`, 1: 1 = a store to an address not in the active table fails; 0 = such stores are ignored.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_we` in 1: write table entry `cfg_idx`; honoured only in IDLE.
- `cfg_idx` in clog2(NUM_CHECKS): table index.
- `cfg_addr` in ADDR_W: expected address.
- `cfg_data` in DATA_W: expected data.
- `cfg_num` in clog2(NUM_CHECKS+1): number of active entries (0..NUM_CHECKS), sampled on start.
- `start` in 1: arm the checker; honoured in IDLE, PASS and FAIL.
- `MemWrite` in 1: core store strobe.
- `DataAddr` in ADDR_W: core store address.
- `WriteData` in DATA_W: core store data.
- `busy` out 1: high in ARMED.
- `pass` out 1: high in PASS.
- `fail` out 1: high in FAIL.
- `fail_code` out 3: 0 none, 1 unexpected address, 2 data mismatch, 3 duplicate store, 4 timeout.
- `fail_addr` out ADDR_W: address of the failing store (0 on timeout).
- `fail_data` out DATA_W: data of the failing store (0 on timeout).
- `match_count` out clog2(NUM_CHECKS+1): entries matched so far.
- `cycle_count` out clog2(TIMEOUT+1): cycles spent in ARMED.

## Operation
- States: IDLE, ARMED, PASS, FAIL. Reset leads to IDLE with every output 0, table cleared to 0, `cfg_num` register 0 and hit bits 0.
- IDLE: `cfg_we` writes the table. On `start`, latch `cfg_num`, clear `match_count`/`cycle_count`/hit bits/`fail_*`, and go to ARMED. If `cfg_num` = 0, go straight to PASS instead.
- ARMED, each cycle: `cycle_count` increments (saturates at TIMEOUT). If `MemWrite` = 0, only the timeout check applies.
- ORDERED = 1, comparing against entry[`match_count`]:
  - Address and data equal: `match_count`+1.
  - Address equal, data differs: FAIL code 2.
  - Address differs: if it equals any later active entry or STRICT = 1, FAIL code 1; otherwise ignore.
  - An earlier, already-matched address: FAIL code 3.
- ORDERED = 0, checking the lowest-index active entry with an equal address:
  - That entry is unhit and data is equal: set its hit bit, `match_count`+1.
  - That entry is unhit and data differs: FAIL code 2.
  - All entries with that address are already hit: FAIL code 3.
  - No entry has that address: FAIL code 1 if STRICT, otherwise ignore.
- `match_count` reaching latched `cfg_num` moves to PASS.
- `cycle_count` reaching TIMEOUT with no completing match moves to FAIL code 4.
- Priority in the same cycle: completing match (PASS) > store failure (codes 1–3) > timeout.
- PASS/FAIL hold until `reset` or `start`. `start` re-arms with the table retained. `cfg_we` is ignored outside IDLE.
- `start` while ARMED is ignored.
- Width rules: compares are full-width equality; counters never wrap.

## Timing
- Every output is registered. A store sampled at edge k is reflected in `match_count`/`pass`/`fail` after edge k, with 1-cycle latency.
- `start` at edge k gives `busy` = 1 after k. `cycle_count` = 1 after k+1.
- Timeout: `fail` after edge k+TIMEOUT when armed at edge k.
- A table write at edge k is visible to a `start` at edge k+1. A simultaneous `cfg_we` and `start` in IDLE writes the entry, and the armed run uses the new value.
- `reset` wins over every other input at any state, mid-run included.

## Test plan
- ORDERED = 1, entry0 = (100, 25), `cfg_num` = 1, start, store (100, 25) at cycle 3 → `pass` = 1 one cycle later, `match_count` = 1, `fail_code` = 0.
- ORDERED = 1, entries (96, 7), (100, 25), stores (100, 25) then (96, 7) → FAIL code 1 after the first store, `fail_addr` = 100, `fail_data` = 25.
- ORDERED = 0, entries (96, 7), (100, 25), stores (100, 25), (96, 7) → PASS. Repeat with (100, 25) twice → FAIL code 3. Repeat with (96, 8) → FAIL code 2, `fail_data` = 8.
- TIMEOUT = 16, `cfg_num` = 1, no stores → `fail` exactly 16 cycles after arming, code 4, `cycle_count` = 16, `fail_addr` = 0.
- STRICT = 0, store (200, 1) while armed → ignored, `busy` stays 1. Same store with STRICT = 1 → FAIL code 1.
- Assert `reset` mid-run with `match_count` = 1 → next cycle all outputs 0, state IDLE. `start` with `cfg_num` = 0 → `pass` = 1 after one edge.
